// File: rtl/uart_rx_fifo.sv
// Byte FIFO between the UART byte receiver and its consumers.
// Storage array plus a registered head stage (out_data/out_valid), so the
// total capacity is DEPTH + 1 bytes. Bytes always pass through the array
// before reaching the head register.
module uart_rx_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    in_data,
  input  logic          in_done,
  output logic [7:0]    out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty,
  output logic          overflow,
  input  logic          ovf_clr
);

  localparam int unsigned CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wp_q;
  logic [AW-1:0] rp_q;
  logic [CW-1:0] count_q;

  logic load_c;
  logic wr_c;
  logic drop_c;

  // Status derived from registered state
  assign count = count_q;
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0) && !out_valid;

  // Head load, write accept and drop decisions for this edge
  always_comb begin
    load_c = (count_q != '0) && (!out_valid || out_ready);
    wr_c   = in_done && (!full || load_c);
    drop_c = in_done && full && !load_c;
  end

  // Storage array write; contents are intentionally not reset
  always_ff @(posedge clk) begin
    if (!reset && wr_c) begin
      mem[wp_q] <= in_data;
    end
  end

  // Pointers, occupancy, head register and sticky overflow
  always_ff @(posedge clk) begin
    if (reset) begin
      wp_q      <= '0;
      rp_q      <= '0;
      count_q   <= '0;
      out_data  <= 8'h00;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (wr_c) begin
        wp_q <= wp_q + AW'(1);
      end

      if (load_c) begin
        out_data  <= mem[rp_q];
        out_valid <= 1'b1;
        rp_q      <= rp_q + AW'(1);
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      case ({wr_c, load_c})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase

      // A drop on the same edge as a clear wins
      if (drop_c) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule
